// File: rtl/periph_resp_router.sv
// Response router for the peripheral interconnect. It records granted slave indices in issue order
// and returns only the head slave's response, registered, to the PE. It also flags protocol violations.
module periph_resp_router #(
  parameter int N_SLAVE         = 16,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [N_SLAVE-1:0]                 data_req_i,
  input  logic [N_SLAVE-1:0]                 data_gnt_i,
  input  logic [N_SLAVE-1:0]                 r_valid_i,
  input  logic [N_SLAVE*DATA_WIDTH-1:0]      r_rdata_i,
  input  logic [N_SLAVE-1:0]                 r_opc_i,
  output logic                               r_valid_o,
  output logic [DATA_WIDTH-1:0]              r_rdata_o,
  output logic                               r_opc_o,
  output logic                               full_o,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding_cnt_o,
  output logic                               order_err_o
);

  localparam int LOG_SLAVE = (N_SLAVE > 1) ? $clog2(N_SLAVE) : 1;
  localparam int PTR_W     = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W     = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  logic [LOG_SLAVE-1:0]  fifo_q [MAX_OUTSTANDING];
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  r_valid_q, r_valid_d;
  logic [DATA_WIDTH-1:0] r_rdata_q, r_rdata_d;
  logic                  r_opc_q, r_opc_d;
  logic                  err_q, err_d;

  logic [N_SLAVE-1:0]    hs_s;
  logic                  push_s;
  logic                  multi_s;
  logic [LOG_SLAVE-1:0]  push_idx_s;
  logic [LOG_SLAVE-1:0]  head_idx_s;
  logic [N_SLAVE-1:0]    head_oh_s;
  logic                  cnt_nz_s;
  logic                  full_s;
  logic                  pop_s;
  logic                  stray_s;
  logic                  push_ok_s;
  logic                  ovf_s;
  logic [DATA_WIDTH-1:0] rdata_sel_s;
  logic                  opc_sel_s;

  // Handshake decode, head selection and next-state computation.
  always_comb begin
    hs_s      = data_req_i & data_gnt_i;
    push_s    = |hs_s;
    multi_s   = |(hs_s & (hs_s - N_SLAVE'(1)));
    push_idx_s = {LOG_SLAVE{1'b0}};
    // Scan downwards so the lowest set bit wins on a multi-hot grant.
    for (int k = N_SLAVE - 1; k >= 0; k--) begin
      push_idx_s = hs_s[k] ? LOG_SLAVE'(k) : push_idx_s;
    end

    head_idx_s  = fifo_q[rd_ptr_q];
    cnt_nz_s    = (cnt_q != {CNT_W{1'b0}});
    full_s      = (cnt_q == CNT_MAX);
    rdata_sel_s = {DATA_WIDTH{1'b0}};
    for (int k = 0; k < N_SLAVE; k++) begin
      head_oh_s[k] = cnt_nz_s && (head_idx_s == LOG_SLAVE'(k));
      rdata_sel_s  = head_oh_s[k] ? r_rdata_i[k*DATA_WIDTH +: DATA_WIDTH] : rdata_sel_s;
    end
    opc_sel_s = |(r_opc_i & head_oh_s);

    pop_s     = |(r_valid_i & head_oh_s);
    stray_s   = |(r_valid_i & ~head_oh_s);
    push_ok_s = push_s & (~full_s | pop_s);
    ovf_s     = push_s & full_s & ~pop_s;

    cnt_d     = cnt_q + CNT_W'(push_ok_s) - CNT_W'(pop_s);
    rd_ptr_d  = pop_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    wr_ptr_d  = push_ok_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    r_valid_d = pop_s;
    r_rdata_d = pop_s ? rdata_sel_s : r_rdata_q;
    r_opc_d   = pop_s ? opc_sel_s : r_opc_q;
    err_d     = err_q | multi_s | stray_s | ovf_s;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        fifo_q[i] <= {LOG_SLAVE{1'b0}};
      end
      rd_ptr_q  <= {PTR_W{1'b0}};
      wr_ptr_q  <= {PTR_W{1'b0}};
      cnt_q     <= {CNT_W{1'b0}};
      r_valid_q <= 1'b0;
      r_rdata_q <= {DATA_WIDTH{1'b0}};
      r_opc_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      if (push_ok_s) begin
        fifo_q[wr_ptr_q] <= push_idx_s;
      end
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      cnt_q     <= cnt_d;
      r_valid_q <= r_valid_d;
      r_rdata_q <= r_rdata_d;
      r_opc_q   <= r_opc_d;
      err_q     <= err_d;
    end
  end

  assign r_valid_o         = r_valid_q;
  assign r_rdata_o         = r_rdata_q;
  assign r_opc_o           = r_opc_q;
  assign full_o            = full_s;
  assign outstanding_cnt_o = cnt_q;
  assign order_err_o       = err_q;

endmodule

// File: tb/tb_periph_resp_router.sv
// Directed, table-driven bench for periph_resp_router (N_SLAVE=16, MAX_OUTSTANDING=4).
module tb_periph_resp_router;

  localparam int NS = 16;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [NS-1:0]   data_req, data_gnt, r_valid_in, r_opc_in;
  logic [NS*DW-1:0] r_rdata_in;
  logic            r_valid_out, r_opc_out, full_out, err_out;
  logic [DW-1:0]   r_rdata_out;
  logic [2:0]      cnt_out;

  periph_resp_router #(.N_SLAVE(NS), .DATA_WIDTH(DW), .MAX_OUTSTANDING(4)) dut (
    .clk(clk), .rst(rst),
    .data_req_i(data_req), .data_gnt_i(data_gnt),
    .r_valid_i(r_valid_in), .r_rdata_i(r_rdata_in), .r_opc_i(r_opc_in),
    .r_valid_o(r_valid_out), .r_rdata_o(r_rdata_out), .r_opc_o(r_opc_out),
    .full_o(full_out), .outstanding_cnt_o(cnt_out), .order_err_o(err_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic [NS-1:0] req;
    logic [NS-1:0] gnt;
    logic [NS-1:0] rv;
    int            sl;
    logic [DW-1:0] data;
    logic [NS-1:0] opc;
    logic          e_valid;
    logic [DW-1:0] e_rdata;
    logic          e_opc;
    logic [2:0]    e_cnt;
    logic          e_err;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  function automatic logic [NS-1:0] b(int n);
    logic [NS-1:0] one;
    one = 16'h0001;
    return one << n;
  endfunction

  function automatic void add(logic r, logic [NS-1:0] req, logic [NS-1:0] gnt, logic [NS-1:0] rv,
                              int sl, logic [DW-1:0] d, logic [NS-1:0] opc, logic ev,
                              logic [DW-1:0] erd, logic eop, logic [2:0] ecnt, logic eerr);
    vec_t v;
    v.rst = r; v.req = req; v.gnt = gnt; v.rv = rv; v.sl = sl; v.data = d; v.opc = opc;
    v.e_valid = ev; v.e_rdata = erd; v.e_opc = eop; v.e_cnt = ecnt; v.e_err = eerr;
    vecs.push_back(v);
  endfunction

  task automatic chk(string nm, int idx, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL vec%0d %s: got %0h expected %0h", idx, nm, act, exp);
    end
  endtask

  task automatic drive(logic r, logic [NS-1:0] req, logic [NS-1:0] gnt, logic [NS-1:0] rv,
                       int sl, logic [DW-1:0] d, logic [NS-1:0] opc);
    rst = r; data_req = req; data_gnt = gnt; r_valid_in = rv; r_opc_in = opc;
    for (int k = 0; k < NS; k++) begin
      r_rdata_in[k*DW +: DW] = (k == sl) ? d : ~d;
    end
  endtask

  initial begin
    int lat;
    logic [15:0] z;
    z = 16'h0000;
    drive(1'b1, z, z, z, 0, 32'h0, z);

    //  rst   req          gnt          rv           sl  data           opc          v     rdata          op    cnt   err
    add(1'b1, z,           z,           z,           0,  32'h0,         z,           1'b0, 32'h0,         1'b0, 3'd0, 1'b0); // 0
    add(1'b0, b(3),        b(3),        z,           0,  32'h0,         z,           1'b0, 32'h0,         1'b0, 3'd1, 1'b0);
    add(1'b0, z,           z,           z,           0,  32'h0,         z,           1'b0, 32'h0,         1'b0, 3'd1, 1'b0);
    add(1'b0, z,           z,           b(3),        3,  32'hDEADBEEF,  z,           1'b1, 32'hDEADBEEF,  1'b0, 3'd0, 1'b0);
    add(1'b0, z,           z,           z,           0,  32'h0,         z,           1'b0, 32'hDEADBEEF,  1'b0, 3'd0, 1'b0);
    add(1'b0, b(5),        b(5),        z,           0,  32'h0,         z,           1'b0, 32'hDEADBEEF,  1'b0, 3'd1, 1'b0); // 5
    add(1'b0, b(15),       b(15),       z,           0,  32'h0,         z,           1'b0, 32'hDEADBEEF,  1'b0, 3'd2, 1'b0);
    add(1'b0, b(0),        b(0),        z,           0,  32'h0,         z,           1'b0, 32'hDEADBEEF,  1'b0, 3'd3, 1'b0);
    add(1'b0, b(7),        b(7),        z,           0,  32'h0,         z,           1'b0, 32'hDEADBEEF,  1'b0, 3'd4, 1'b0);
    add(1'b0, z,           z,           b(5),        5,  32'h5,         z,           1'b1, 32'h5,         1'b0, 3'd3, 1'b0);
    add(1'b0, z,           z,           b(15),       15, 32'hF,         16'h8000,    1'b1, 32'hF,         1'b1, 3'd2, 1'b0); // 10
    add(1'b0, z,           z,           b(0),        0,  32'h0,         z,           1'b1, 32'h0,         1'b0, 3'd1, 1'b0);
    add(1'b0, z,           z,           b(7),        7,  32'h7,         z,           1'b1, 32'h7,         1'b0, 3'd0, 1'b0);
    add(1'b0, b(1),        b(1),        z,           0,  32'h0,         z,           1'b0, 32'h7,         1'b0, 3'd1, 1'b0);
    add(1'b0, b(2),        b(2),        z,           0,  32'h0,         z,           1'b0, 32'h7,         1'b0, 3'd2, 1'b0);
    add(1'b0, b(3),        b(3),        z,           0,  32'h0,         z,           1'b0, 32'h7,         1'b0, 3'd3, 1'b0); // 15
    add(1'b0, b(4),        b(4),        z,           0,  32'h0,         z,           1'b0, 32'h7,         1'b0, 3'd4, 1'b0);
    add(1'b0, b(9),        b(9),        b(1),        1,  32'h11,        z,           1'b1, 32'h11,        1'b0, 3'd4, 1'b0);
    add(1'b0, z,           z,           b(2),        2,  32'h22,        z,           1'b1, 32'h22,        1'b0, 3'd3, 1'b0);
    add(1'b0, z,           z,           b(3),        3,  32'h33,        z,           1'b1, 32'h33,        1'b0, 3'd2, 1'b0);
    add(1'b0, z,           z,           b(4),        4,  32'h44,        z,           1'b1, 32'h44,        1'b0, 3'd1, 1'b0); // 20
    add(1'b0, z,           z,           b(9),        9,  32'h99,        z,           1'b1, 32'h99,        1'b0, 3'd0, 1'b0);
    add(1'b0, b(2),        b(2),        z,           0,  32'h0,         z,           1'b0, 32'h99,        1'b0, 3'd1, 1'b0);
    add(1'b0, b(4),        b(4),        z,           0,  32'h0,         z,           1'b0, 32'h99,        1'b0, 3'd2, 1'b0);
    add(1'b0, z,           z,           b(4),        4,  32'h44,        z,           1'b0, 32'h99,        1'b0, 3'd2, 1'b1);
    add(1'b0, z,           z,           b(2),        2,  32'h2,         z,           1'b1, 32'h2,         1'b0, 3'd1, 1'b1); // 25
    add(1'b0, z,           z,           b(4),        4,  32'h4,         z,           1'b1, 32'h4,         1'b0, 3'd0, 1'b1);
    add(1'b1, z,           z,           z,           0,  32'h0,         z,           1'b0, 32'h0,         1'b0, 3'd0, 1'b0);
    add(1'b0, z,           z,           b(6),        6,  32'h6,         z,           1'b0, 32'h0,         1'b0, 3'd0, 1'b1);
    add(1'b1, z,           z,           z,           0,  32'h0,         z,           1'b0, 32'h0,         1'b0, 3'd0, 1'b0);
    add(1'b0, b(10),       b(10),       z,           0,  32'h0,         z,           1'b0, 32'h0,         1'b0, 3'd1, 1'b0); // 30
    add(1'b0, b(11),       b(11),       z,           0,  32'h0,         z,           1'b0, 32'h0,         1'b0, 3'd2, 1'b0);
    add(1'b0, b(12),       b(12),       z,           0,  32'h0,         z,           1'b0, 32'h0,         1'b0, 3'd3, 1'b0);
    add(1'b0, b(13),       b(13),       z,           0,  32'h0,         z,           1'b0, 32'h0,         1'b0, 3'd4, 1'b0);
    add(1'b0, b(1),        b(1),        z,           0,  32'h0,         z,           1'b0, 32'h0,         1'b0, 3'd4, 1'b1);
    add(1'b1, z,           z,           z,           0,  32'h0,         z,           1'b0, 32'h0,         1'b0, 3'd0, 1'b0); // 35
    add(1'b0, b(1),        b(1),        z,           0,  32'h0,         z,           1'b0, 32'h0,         1'b0, 3'd1, 1'b0);
    add(1'b0, b(2),        b(2),        z,           0,  32'h0,         z,           1'b0, 32'h0,         1'b0, 3'd2, 1'b0);
    add(1'b0, b(3),        b(3),        z,           0,  32'h0,         z,           1'b0, 32'h0,         1'b0, 3'd3, 1'b0);
    add(1'b1, z,           z,           z,           0,  32'h0,         z,           1'b0, 32'h0,         1'b0, 3'd0, 1'b0);
    add(1'b0, b(6),        b(6),        z,           0,  32'h0,         z,           1'b0, 32'h0,         1'b0, 3'd1, 1'b0); // 40
    add(1'b0, z,           z,           b(6),        6,  32'h66,        16'h0040,    1'b1, 32'h66,        1'b1, 3'd0, 1'b0);
    add(1'b0, 16'h000C,    16'h000C,    z,           0,  32'h0,         z,           1'b0, 32'h66,        1'b1, 3'd1, 1'b1);
    add(1'b0, z,           z,           b(2),        2,  32'h2,         z,           1'b1, 32'h2,         1'b0, 3'd0, 1'b1);
    add(1'b1, z,           z,           z,           0,  32'h0,         z,           1'b0, 32'h0,         1'b0, 3'd0, 1'b0);
    add(1'b0, 16'h0120,    16'h0100,    z,           0,  32'h0,         z,           1'b0, 32'h0,         1'b0, 3'd1, 1'b0); // 45
    add(1'b0, z,           z,           16'h0300,    8,  32'h88,        z,           1'b1, 32'h88,        1'b0, 3'd0, 1'b1);
    add(1'b1, z,           z,           z,           0,  32'h0,         z,           1'b0, 32'h0,         1'b0, 3'd0, 1'b0);
    add(1'b0, b(3),        b(3),        z,           0,  32'h0,         z,           1'b0, 32'h0,         1'b0, 3'd1, 1'b0);
    add(1'b0, b(3),        b(3),        b(3),        3,  32'h33,        z,           1'b1, 32'h33,        1'b0, 3'd1, 1'b0);
    add(1'b0, z,           z,           b(3),        3,  32'h34,        z,           1'b1, 32'h34,        1'b0, 3'd0, 1'b0); // 50
    add(1'b0, b(5),        b(5),        b(5),        5,  32'h55,        z,           1'b0, 32'h34,        1'b0, 3'd1, 1'b1);
    add(1'b0, z,           z,           b(5),        5,  32'h56,        z,           1'b1, 32'h56,        1'b0, 3'd0, 1'b1);

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].req, vecs[i].gnt, vecs[i].rv, vecs[i].sl, vecs[i].data, vecs[i].opc);
      @(posedge clk);
      #1;
      chk("r_valid", i, 64'(r_valid_out), 64'(vecs[i].e_valid));
      chk("r_rdata", i, 64'(r_rdata_out), 64'(vecs[i].e_rdata));
      chk("r_opc",   i, 64'(r_opc_out),   64'(vecs[i].e_opc));
      chk("cnt",     i, 64'(cnt_out),     64'(vecs[i].e_cnt));
      chk("full",    i, 64'(full_out),    64'(vecs[i].e_cnt == 3'd4));
      chk("err",     i, 64'(err_out),     64'(vecs[i].e_err));
    end

    // Latency sequence: one-cycle response pulse, then a bounded wait for the return.
    drive(1'b1, z, z, z, 0, 32'h0, z);
    @(posedge clk); #1;
    drive(1'b0, b(12), b(12), z, 0, 32'h0, z);
    @(posedge clk); #1;
    drive(1'b0, z, z, b(12), 12, 32'hCAFE0012, z);
    lat = 0;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      drive(1'b0, z, z, z, 0, 32'h0, z);
      if (r_valid_out === 1'b1 && lat == 0) lat = c;
    end
    chk("latency", 100, 64'(lat), 64'd1);
    chk("lat_rdata", 100, 64'(r_rdata_out), 64'hCAFE0012);
    chk("lat_cnt", 100, 64'(cnt_out), 64'd0);
    chk("lat_err", 100, 64'(err_out), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
